rom_prefetch: RTL

ROM_PREFETCH -- requirements
Module: rom_prefetch

---
 rtl/rom_prefetch.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rom_prefetch.sv
// Purpose : prefetches sequential ROM bytes into a small FIFO for an opcode consumer, with jump flush/redirect.
// Latency : one byte per 3 cycles (IDLE->ADDR->READ); byte_valid rises on the edge closing READ, 3 edges after reset release or a jump.
// Backpress: byte_ready low lets the FIFO fill to DEPTH, then the FSM parks in IDLE with rom_dataeno low until a pop frees a slot.
//
// Ports:
//   clock, reset         : single clock, synchronous active-low reset
//   rom_addr/rom_dataeno : ROM byte address (always fetch_pc) and output enable (high only in READ)
//   rom_data             : ROM read data, captured at the edge that closes READ
//   jmp_valid/jmp_addr   : one-cycle flush-and-redirect; overrides every other event except reset
//   byte_valid/byte_data/byte_addr/byte_ready : FIFO head with valid/ready handshake
module rom_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [10:0] rom_addr,
    output logic        rom_dataeno,
    input  logic [7:0]  rom_data,
    input  logic        jmp_valid,
    input  logic [10:0] jmp_addr,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic [10:0] byte_addr,
    input  logic        byte_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        READ = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [10:0]     fetch_pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic            push;
    logic            pop;

    // Next-state and ROM-side outputs.
    always_comb begin
        state_nxt   = state;
        rom_dataeno = 1'b0;
        case (state)
            IDLE: begin
                // Only enter a fetch when a slot is guaranteed for its push.
                if (count < CW'(DEPTH)) begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                state_nxt = READ;
            end
            READ: begin
                rom_dataeno = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rom_addr = fetch_pc;
    assign push     = (state == READ);
    assign pop      = byte_valid && byte_ready;

    // Control state. Jump beats push/pop; reset beats jump.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= 11'h000;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (jmp_valid) begin
            state    <= IDLE;
            fetch_pc <= jmp_addr;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 11'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible when count is nonzero.
    always_ff @(posedge clock) begin
        if (reset && !jmp_valid && push) begin
            mem[wr_ptr] <= '{addr: fetch_pc, data: rom_data};
        end
    end

    // Head is presented straight from storage, masked to zero when empty.
    assign head       = mem[rd_ptr];
    assign byte_valid = (count != '0);
    assign byte_data  = byte_valid ? head.data : 8'h00;
    assign byte_addr  = byte_valid ? head.addr : 11'h000;

endmodule
